// File: rtl/minhash_indexer.sv
// rtl/minhash_indexer.sv - scans every k-mer of a fragment and keeps the INDICES_COUNT smallest hashes with positions.
// Optional: define MINHASH_DEDUP_EN to discard candidates whose hash already sits in a valid slot.
module minhash_indexer #(
  parameter int KMER_LEN      = 4,
  parameter int BASE_LEN      = 4,
  parameter int MEM_LEN       = 128,
  parameter int INDICES_COUNT = 2,
  parameter int INDICE_LEN    = 5,
  parameter int HASH_LEN      = 16,
  parameter logic [HASH_LEN-1:0] HASH_SEED = 16'h0000
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [MEM_LEN-1:0]                           memory,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]     kmer_indices,
  output logic [INDICES_COUNT-1:0][HASH_LEN-1:0]       kmer_hashes,
  output logic [INDICES_COUNT-1:0]                     slot_valid
);

  localparam int NBASES = MEM_LEN / BASE_LEN;
  localparam int NPOS   = NBASES - KMER_LEN + 1;

  if (NPOS < INDICES_COUNT || NPOS > 2**INDICE_LEN) begin : g_bad_npos
    $error("minhash_indexer: k-mer position count out of range");
  end
  if (HASH_LEN != KMER_LEN * BASE_LEN) begin : g_bad_hash_len
    $error("minhash_indexer: HASH_LEN must equal KMER_LEN*BASE_LEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                                     state_q, state_d;
  logic [MEM_LEN-1:0]                         mem_q, mem_d;
  logic [INDICE_LEN-1:0]                      pos_q, pos_d;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]   idx_q, idx_d;
  logic [INDICES_COUNT-1:0][HASH_LEN-1:0]     hash_q, hash_d;
  logic [INDICES_COUNT-1:0]                   vld_q, vld_d;

  int unsigned                                sh_amt;
  logic [MEM_LEN-1:0]                         shifted;
  logic [HASH_LEN-1:0]                        cand_hash;
  logic [INDICES_COUNT-1:0]                   beats;
  logic                                       dup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mem_q   <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      hash_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_SCAN;
      S_SCAN: if (pos_q == INDICE_LEN'(NPOS - 1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Base pos sits at the top after shifting, so the k-mer is the top HASH_LEN bits.
  always_comb begin
    sh_amt    = BASE_LEN * 32'(pos_q);
    shifted   = mem_q << sh_amt;
    cand_hash = shifted[MEM_LEN-1 -: HASH_LEN] ^ HASH_SEED;
  end

  // Slots stay sorted with invalid ones on top, so beats[] is monotone.
  always_comb begin
    beats = '0;
    dup   = 1'b0;
    for (int i = 0; i < INDICES_COUNT; i++) begin
      beats[i] = !vld_q[i] || (cand_hash < hash_q[i]);
`ifdef MINHASH_DEDUP_EN
      if (vld_q[i] && (hash_q[i] == cand_hash)) dup = 1'b1;
`endif
    end
  end

  always_comb begin
    mem_d  = mem_q;
    pos_d  = pos_q;
    idx_d  = idx_q;
    hash_d = hash_q;
    vld_d  = vld_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mem_d  = memory;
          pos_d  = '0;
          idx_d  = '0;
          hash_d = '1;
          vld_d  = '0;
        end
      end
      S_SCAN: begin
        pos_d = pos_q + 1'b1;
        if (!dup) begin
          if (beats[0]) begin
            idx_d[0]  = pos_q;
            hash_d[0] = cand_hash;
            vld_d[0]  = 1'b1;
          end
          for (int i = 1; i < INDICES_COUNT; i++) begin
            if (beats[i]) begin
              if (!beats[i-1]) begin
                idx_d[i]  = pos_q;
                hash_d[i] = cand_hash;
                vld_d[i]  = 1'b1;
              end else begin
                idx_d[i]  = idx_q[i-1];
                hash_d[i] = hash_q[i-1];
                vld_d[i]  = vld_q[i-1];
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    out_valid    = (state_q == S_DONE);
    kmer_indices = '0;
    kmer_hashes  = '0;
    slot_valid   = '0;
    if (state_q == S_DONE) begin
      kmer_indices = idx_q;
      kmer_hashes  = hash_q;
      slot_valid   = vld_q;
    end
  end

endmodule

// File: tb/tb_minhash_indexer.sv
// tb/tb_minhash_indexer.sv - scoreboard bench for minhash_indexer with directed fragment vectors.
module tb_minhash_indexer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] memory;
  logic         out_valid;
  logic         out_ready;
  logic [9:0]   kmer_indices;
  logic [31:0]  kmer_hashes;
  logic [1:0]   slot_valid;

  always #5 clk = ~clk;

  minhash_indexer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .memory       (memory),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .kmer_indices (kmer_indices),
    .kmer_hashes  (kmer_hashes),
    .slot_valid   (slot_valid)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [9:0]  exp_idx_q[$];
  logic [31:0] exp_hash_q[$];
  logic [1:0]  exp_vld_q[$];

  localparam logic [127:0] V1_MEM  = 128'h01234567899876543210001122334455;
  localparam logic [9:0]   V1_IDX  = {5'd20, 5'd19};
  localparam logic [31:0]  V1_HASH = {16'h0011, 16'h0001};

  localparam logic [127:0] V3_MEM  = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] V4_MEM  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] V5_MEM  = {128{1'b1}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [9:0] idx, input logic [31:0] hsh, input logic [1:0] vld);
    exp_idx_q.push_back(idx);
    exp_hash_q.push_back(hsh);
    exp_vld_q.push_back(vld);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_idx_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        chk("kmer_indices", 64'(kmer_indices), 64'(exp_idx_q.pop_front()));
        chk("kmer_hashes",  64'(kmer_hashes),  64'(exp_hash_q.pop_front()));
        chk("slot_valid",   64'(slot_valid),   64'(exp_vld_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [127:0] m);
    int guard;
    guard    = 0;
    memory   = m;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_timeout", 64'(guard < 200), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input logic [127:0] m, input logic [9:0] idx,
                         input logic [31:0] hsh, input logic [1:0] vld);
    int cyc;
    expect_result(idx, hsh, vld);
    issue(m);
    wait_out(cyc);
    chk("latency", 64'(cyc), 64'd29);
    @(posedge clk); #1;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready",  64'(in_ready),  64'd1);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    memory    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_indices",   64'(kmer_indices), 64'd0);
    chk("rst_hashes",    64'(kmer_hashes),  64'd0);
    chk("rst_slot_vld",  64'(slot_valid),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec(V1_MEM, V1_IDX, V1_HASH, 2'b11);
`ifdef MINHASH_DEDUP_EN
    run_vec('0,     {5'd0, 5'd0},  {16'hFFFF, 16'h0000}, 2'b01);
    run_vec(V4_MEM, {5'd1, 5'd0},  {16'h1234, 16'h0123}, 2'b11);
    run_vec(V5_MEM, {5'd0, 5'd0},  {16'hFFFF, 16'hFFFF}, 2'b01);
`else
    run_vec('0,     {5'd1, 5'd0},  {16'h0000, 16'h0000}, 2'b11);
    run_vec(V4_MEM, {5'd16, 5'd0}, {16'h0123, 16'h0123}, 2'b11);
    run_vec(V5_MEM, {5'd1, 5'd0},  {16'hFFFF, 16'hFFFF}, 2'b11);
`endif
    run_vec(V3_MEM, {5'd14, 5'd15}, {16'h10FE, 16'h0FED}, 2'b11);

    // Backpressure: DONE must hold its outputs until out_ready.
    out_ready = 1'b0;
    expect_result(V1_IDX, V1_HASH, 2'b11);
    issue(V1_MEM);
    wait_out(cyc);
    chk("bp_latency", 64'(cyc), 64'd29);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid),    64'd1);
      chk("bp_in_ready",  64'(in_ready),     64'd0);
      chk("bp_indices",   64'(kmer_indices), 64'(V1_IDX));
      chk("bp_hashes",    64'(kmer_hashes),  64'(V1_HASH));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);

    // Reset in the middle of a scan discards the job.
    issue(V3_MEM);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(in_ready),     64'd1);
    chk("mid_rst_out_valid", 64'(out_valid),    64'd0);
    chk("mid_rst_indices",   64'(kmer_indices), 64'd0);
    chk("mid_rst_hashes",    64'(kmer_hashes),  64'd0);
    chk("mid_rst_slot_vld",  64'(slot_valid),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(V1_MEM, V1_IDX, V1_HASH, 2'b11);

    // Back-to-back jobs with in_valid held high.
    expect_result(V1_IDX, V1_HASH, 2'b11);
    expect_result({5'd14, 5'd15}, {16'h10FE, 16'h0FED}, 2'b11);
    memory   = V1_MEM;
    in_valid = 1'b1;
    @(posedge clk); #1;
    memory = V3_MEM;
    wait_out(cyc);
    chk("b2b_latency1", 64'(cyc), 64'd29);
    @(posedge clk); #1;
    cyc = 1;
    chk("b2b_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    cyc = 2;
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(in_ready), 64'd0);
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_spacing", 64'(cyc), 64'd31);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_idx_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
